fifo_pixelq_shreg_ctrl: RTL
===========================

Name: fifo_pixelq_shreg_ctrl

Overview:
- Control half of the pixel-queue channel FIFO.
- Owns the occupancy pointer, the full/empty flags and the read/write handshake.
- Sequences an external addressable shift-register store: shift-enable, write data and read address; read data returns combinationally.
- Instantiated once per image-dimension channel (rows/cols) between producer and consumer dataflow processes.

Parameters:
- DATA_WIDTH, 12: width of each stored word.
- ADDR_WIDTH, 2: width of the shift-register read address; must satisfy 2^ADDR_WIDTH >= DEPTH.
- DEPTH, 3: number of storage entries (>= 1).

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- if_write_ce  in  1  write-side clock enable; write ignored when low.
- if_write  in  1  producer write request.
- if_din  in  DATA_WIDTH  producer data.
- if_full_n  out  1  registered; high = space available.
- if_read_ce  in  1  read-side clock enable; read ignored when low.
- if_read  in  1  consumer read request.
- if_dout  out  DATA_WIDTH  head-of-queue data (combinational from shreg_q).
- if_empty_n  out  1  registered; high = data available.
- if_count  out  ADDR_WIDTH+1  registered occupancy, 0..DEPTH.
- shreg_ce  out  1  shift enable to storage.
- shreg_data  out  DATA_WIDTH  word shifted into storage (= if_din).
- shreg_a  out  ADDR_WIDTH  storage read address.
- shreg_q  in  DATA_WIDTH  storage read data.

Behaviour:
- Pointer ptr is ADDR_WIDTH+1 bits, two's complement. Reset value is all-ones (-1 = empty). Legal range is -1..DEPTH-1.
- Accepted write: wr_acc = if_write & if_write_ce & if_full_n.
- Accepted read: rd_acc = if_read & if_read_ce & if_empty_n.
- shreg_ce = wr_acc (combinational). shreg_data = if_din.
- shreg_a = ptr[ADDR_WIDTH-1:0]. if_dout = shreg_q. if_dout is don't-care while if_empty_n=0.
- Pointer update at each clk edge:
  - wr_acc only: ptr+1.
  - rd_acc only: ptr-1.
  - both: ptr unchanged. The shift moves the oldest word to the same index, so the read address stays correct.
  - neither: hold.
- Flags, registered, computed from ptr_next:
  - if_empty_n <= (ptr_next != -1).
  - if_full_n <= (ptr_next != DEPTH-1).
  - if_count <= ptr_next + 1.
- Reset values (asynchronous, immediate on reset_n low): if_empty_n=0, if_full_n=1, if_count=0, ptr=-1.
- Latency: a word written at edge N is visible on if_dout with if_empty_n=1 after edge N. Write-to-read latency is 1 cycle.
- Full: writes are refused and shreg_ce stays 0. A simultaneous read is accepted; if_full_n rises next cycle.
- Empty: reads are refused. A simultaneous write is accepted; if_empty_n rises next cycle.
- Pointer must never leave -1..DEPTH-1. No wrap-around is possible because the flags gate acceptance.
- Reset mid-operation: queue contents are discarded logically (pointer only). Storage is not cleared.
- DEPTH=1: full and empty are mutually exclusive and alternate. Simultaneous read+write never occurs.

Optional Feature:
- Macro: FIFO_PIXELQ_CTRL_STATS_EN.
- When defined, adds two outputs:
  - err_overflow (1): sticky; set when if_write & if_write_ce while if_full_n=0.
  - err_underflow (1): sticky; set when if_read & if_read_ce while if_empty_n=0.
- Both flags clear only on reset_n low. Reset value 0.
- When undefined: neither port nor logic exists. Behaviour is otherwise identical.

Test Plan (DATA_WIDTH=12, ADDR_WIDTH=2, DEPTH=3):
1. Reset: assert reset_n=0 mid-cycle -> outputs change immediately to if_empty_n=0, if_full_n=1, if_count=0; shreg_ce=0 after release.
2. Fill: write 0x101, 0x202, 0x303 on consecutive cycles -> if_count 1,2,3; if_full_n=0 after third edge; if_dout=0x101 from first edge on; a fourth write 0x404 produces shreg_ce=0 and if_count stays 3.
3. Drain: from full, read on 3 cycles -> if_dout sequence 0x101, 0x202, 0x303; if_empty_n=0 after third edge; an extra read leaves if_count=0.
4. Simultaneous: count=2 (0x0AA, 0x0BB), read+write 0x0CC -> count stays 2, shreg_a unchanged, if_dout becomes 0x0BB, then 0x0CC after one more read.
5. Clock enables: if_write=1 with if_write_ce=0, and if_read=1 with if_read_ce=0 -> no shreg_ce, count unchanged for 5 cycles.
6. FIFO_PIXELQ_CTRL_STATS_EN defined: write while full -> err_overflow=1 and stays 1 through subsequent normal traffic; read while empty -> err_underflow=1; reset_n low clears both.

Source files
------------

// File: rtl/fifo_pixelq_shreg_ctrl.sv
// Control half of the pixel-queue channel FIFO: pointer, flags and shift-register sequencing.
// Optional sticky overflow/underflow flags are built when FIFO_PIXELQ_CTRL_STATS_EN is defined.
module fifo_pixelq_shreg_ctrl #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 2,
    parameter int DEPTH      = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   if_count,
    output logic                  shreg_ce,
    output logic [DATA_WIDTH-1:0] shreg_data,
    output logic [ADDR_WIDTH-1:0] shreg_a,
    input  logic [DATA_WIDTH-1:0] shreg_q
`ifdef FIFO_PIXELQ_CTRL_STATS_EN
    ,
    output logic                  err_overflow,
    output logic                  err_underflow
`endif
);

    localparam int PW = ADDR_WIDTH + 1;
    // -1 marks an empty queue; DEPTH-1 marks a full one.
    localparam logic [PW-1:0] PTR_EMPTY = {PW{1'b1}};
    localparam logic [PW-1:0] PTR_FULL  = PW'(DEPTH - 1);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_next;
    logic          w_wr_acc;
    logic          w_rd_acc;

    assign w_wr_acc   = if_write & if_write_ce & if_full_n;
    assign w_rd_acc   = if_read & if_read_ce & if_empty_n;
    assign shreg_ce   = w_wr_acc;
    assign shreg_data = if_din;
    assign shreg_a    = r_ptr[ADDR_WIDTH-1:0];
    assign if_dout    = shreg_q;

    // Next pointer; a simultaneous read and write leaves the head at the same index.
    always_comb begin
        w_ptr_next = r_ptr;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_ptr_next = r_ptr + PW'(1);
            2'b01:   w_ptr_next = r_ptr - PW'(1);
            default: w_ptr_next = r_ptr;
        endcase
    end

    // Pointer and registered status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr      <= PTR_EMPTY;
            if_empty_n <= 1'b0;
            if_full_n  <= 1'b1;
            if_count   <= {PW{1'b0}};
        end else begin
            r_ptr      <= w_ptr_next;
            if_empty_n <= (w_ptr_next != PTR_EMPTY);
            if_full_n  <= (w_ptr_next != PTR_FULL);
            if_count   <= w_ptr_next + PW'(1);
        end
    end

`ifdef FIFO_PIXELQ_CTRL_STATS_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky protocol-error flags, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= r_overflow  | (if_write & if_write_ce & ~if_full_n);
            r_underflow <= r_underflow | (if_read & if_read_ce & ~if_empty_n);
        end
    end

    assign err_overflow  = r_overflow;
    assign err_underflow = r_underflow;
`endif

endmodule
